// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: datapath widths, HALT opcode, NOP word and FSM states.
package cpu_pkg;

  localparam int INST_W = 16;
  localparam int PC_W   = 8;
  localparam int PERF_W = 16;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0]   OP_HALT = 5'b11111;
  localparam logic [INST_W-1:0] NOP     = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  function automatic logic is_halt(input logic [INST_W-1:0] inst);
    return inst[INST_W-1 -: OP_W] == OP_HALT;
  endfunction

endpackage

// File: rtl/if_ctrl_perf.sv
// Saturating event counters for the fetch stage (fetch, stall, flush), one per inc bit.
module if_ctrl_perf
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             inc,
  output logic [2:0][PERF_W-1:0] cnt
);

  logic [PERF_W-1:0] cnt_reg [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg[gi] <= '0;
      end else if (inc[gi] && (cnt_reg[gi] != {PERF_W{1'b1}})) begin
        cnt_reg[gi] <= cnt_reg[gi] + PERF_W'(1);
      end
    end
    assign cnt[gi] = cnt_reg[gi];
  end

endmodule

// File: rtl/if_ctrl.sv
// Instruction-fetch controller: drives the external ROM address and registers the IF/ID stage.
// Optional performance counters are built when IF_CTRL_PERF_CNT_EN is defined.
module if_ctrl
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst_out,
  output logic [PC_W-1:0]   pc_out,
  output logic              inst_valid,
  output logic              halted
`ifdef IF_CTRL_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] fetch_cnt,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  state_t              state_reg;
  logic [PC_W-1:0]     pc_reg;
  logic [INST_W-1:0]   inst_reg;
  logic [PC_W-1:0]     pcout_reg;
  logic                valid_reg;

  // Priority: redirect, then stall, then start, then normal fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      inst_reg  <= NOP;
      pcout_reg <= '0;
      valid_reg <= 1'b0;
    end else if (branch_taken) begin
      // A redirect also cancels a speculative HALT, so HALT returns to RUN.
      pc_reg    <= branch_target;
      inst_reg  <= NOP;
      valid_reg <= 1'b0;
      if (state_reg == HALT) begin
        state_reg <= RUN;
      end
    end else if (!stall) begin
      if (start && (state_reg != RUN)) begin
        state_reg <= RUN;
        pc_reg    <= RESET_PC;
        inst_reg  <= NOP;
        valid_reg <= 1'b0;
      end else if (state_reg == RUN) begin
        inst_reg  <= imem_rdata;
        pcout_reg <= pc_reg;
        valid_reg <= 1'b1;
        if (is_halt(imem_rdata)) begin
          state_reg <= HALT;
        end else begin
          pc_reg <= pc_reg + PC_W'(1);
        end
      end else begin
        inst_reg  <= NOP;
        valid_reg <= 1'b0;
      end
    end
  end

  assign imem_addr  = pc_reg;
  assign inst_out   = inst_reg;
  assign pc_out     = pcout_reg;
  assign inst_valid = valid_reg;
  assign halted     = (state_reg == HALT);

`ifdef IF_CTRL_PERF_CNT_EN
  logic [2:0][PERF_W-1:0] perf_cnt;
  logic                   stall_inc;

  assign stall_inc = (state_reg == RUN) && stall && !branch_taken;

  if_ctrl_perf u_perf (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ({branch_taken, stall_inc, valid_reg}),
    .cnt   (perf_cnt)
  );

  assign fetch_cnt = perf_cnt[0];
  assign stall_cnt = perf_cnt[1];
  assign flush_cnt = perf_cnt[2];
`endif

endmodule

// File: tb/tb_if_ctrl.sv
// Table-driven bench for if_ctrl: per-cycle vectors plus hand-written reset/saturation sequences.
module tb_if_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] inst_out;
  logic [7:0]  pc_out;
  logic        inst_valid;
  logic        halted;
`ifdef IF_CTRL_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  logic [15:0] rom [256];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_rdata = rom[imem_addr];

  if_ctrl #(.RESET_PC(8'h00)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .inst_out      (inst_out),
    .pc_out        (pc_out),
    .inst_valid    (inst_valid),
    .halted        (halted)
`ifdef IF_CTRL_PERF_CNT_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  typedef struct {
    logic        st;
    logic        sl;
    logic        br;
    logic [7:0]  tg;
    logic [7:0]  addr;
    logic [15:0] inst;
    logic [7:0]  pco;
    logic        v;
    logic        h;
  } vec_t;

  vec_t vecs[$];

  // Normal ROM word: opcode 5'b00001 with the address in the low byte.
  function automatic logic [15:0] w(input int a);
    return 16'h0800 | {8'h00, 8'(a)};
  endfunction

  // HALT word: opcode 5'b11111.
  function automatic logic [15:0] h(input int a);
    return 16'hF800 | {8'h00, 8'(a)};
  endfunction

  task automatic add(input logic st, input logic sl, input logic br, input int tg,
                     input int addr, input logic [15:0] inst, input int pco,
                     input logic v, input logic hl);
    vec_t r;
    r.st = st; r.sl = sl; r.br = br; r.tg = 8'(tg);
    r.addr = 8'(addr); r.inst = inst; r.pco = 8'(pco); r.v = v; r.h = hl;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] a, input logic [15:0] i,
                         input logic [7:0] p, input logic v, input logic hl);
    chk({tag, ".imem_addr"},  32'(imem_addr),  32'(a));
    chk({tag, ".inst_out"},   32'(inst_out),   32'(i));
    chk({tag, ".pc_out"},     32'(pc_out),     32'(p));
    chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(v));
    chk({tag, ".halted"},     32'(halted),     32'(hl));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = w(i);
    rom[8]  = h(8);
    rom[23] = h(23);

    rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;

    // Rows: start, stall, branch, target | imem_addr, inst_out, pc_out, inst_valid, halted
    add(1, 0, 0, 0,   8'h00, 16'h0000, 8'h00, 0, 0);
    add(0, 0, 0, 0,   1, w(0), 0, 1, 0);
    for (int a = 1; a <= 4; a++) add(0, 0, 0, 0, a + 1, w(a), a, 1, 0);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 5, w(4), 4, 1, 0);
    add(0, 1, 1, 9,   9, 16'h0000, 4, 0, 0);
    for (int a = 9; a <= 22; a++) add(0, 0, 0, 0, a + 1, w(a), a, 1, 0);
    add(0, 0, 0, 0,   23, h(23), 23, 1, 1);
    add(0, 0, 0, 0,   23, 16'h0000, 23, 0, 1);
    add(0, 0, 0, 0,   23, 16'h0000, 23, 0, 1);
    add(0, 0, 1, 12,  12, 16'h0000, 23, 0, 0);
    add(0, 0, 0, 0,   13, w(12), 12, 1, 0);
    add(0, 0, 1, 8,   8, 16'h0000, 12, 0, 0);
    add(0, 0, 1, 2,   2, 16'h0000, 12, 0, 0);
    add(0, 0, 0, 0,   3, w(2), 2, 1, 0);
    add(1, 0, 0, 0,   4, w(3), 3, 1, 0);
    add(0, 0, 1, 'hFE, 'hFE, 16'h0000, 3, 0, 0);
    add(0, 0, 0, 0,   'hFF, w('hFE), 'hFE, 1, 0);
    add(0, 0, 0, 0,   'h00, w('hFF), 'hFF, 1, 0);
    add(0, 0, 1, 23,  23, 16'h0000, 'hFF, 0, 0);
    add(0, 0, 0, 0,   23, h(23), 23, 1, 1);
    add(0, 0, 0, 0,   23, 16'h0000, 23, 0, 1);
    add(1, 0, 0, 0,   0, 16'h0000, 23, 0, 0);
    add(0, 0, 0, 0,   1, w(0), 0, 1, 0);

    // Reset values: asynchronously, then across an edge.
    #1;
    chk_all("rst_async", 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("rst_edge", 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; stall = vecs[i].sl;
      branch_taken = vecs[i].br; branch_target = vecs[i].tg;
      @(posedge clk); #1;
      chk_all($sformatf("row%0d", i), vecs[i].addr, vecs[i].inst, vecs[i].pco, vecs[i].v, vecs[i].h);
      $display("row %0d: st=%0b sl=%0b br=%0b tg=%h -> addr=%h inst=%h pc=%h v=%0b h=%0b",
               i, vecs[i].st, vecs[i].sl, vecs[i].br, vecs[i].tg,
               imem_addr, inst_out, pc_out, inst_valid, halted);
    end
    start = 1'b0; stall = 1'b0; branch_taken = 1'b0;

`ifdef IF_CTRL_PERF_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd3);
    chk("flush_cnt", 32'(flush_cnt), 32'd6);
    $display("perf: fetch=%0d stall=%0d flush=%0d", fetch_cnt, stall_cnt, flush_cnt);
`endif

    // Reset mid-cycle with a redirect pending: reset wins and the redirect is dropped.
    branch_taken = 1'b1; branch_target = 8'h40;
    #2; rst_n = 1'b0; #1;
    chk_all("midrst_async", 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    branch_taken = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("midrst_idle", 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0);
    $display("midrst: addr=%h inst=%h v=%0b h=%0b", imem_addr, inst_out, inst_valid, halted);

`ifdef IF_CTRL_PERF_CNT_EN
    chk("cnt_rst", 32'({fetch_cnt, stall_cnt}), 32'd0);
    rom[8]  = w(8);
    rom[23] = w(23);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (65600) @(posedge clk);
    #1;
    chk("fetch_sat", 32'(fetch_cnt), 32'h0000FFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("fetch_hold", 32'(fetch_cnt), 32'h0000FFFF);
    $display("sat: fetch_cnt=%h", fetch_cnt);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
